// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - Memory stage: latches EX results, runs byte/word loads and stores over req/ack
// Optional feature macro: MEM_TIMEOUT_EN (aborts an ACCESS after TIMEOUT_CYCLES edges without ack).
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 8
`endif
`ifndef OP_ADD
`define OP_ADD 8'h01
`endif
`ifndef OP_LDB
`define OP_LDB 8'h20
`endif
`ifndef OP_LDW
`define OP_LDW 8'h21
`endif
`ifndef OP_STB
`define OP_STB 8'h22
`endif
`ifndef OP_STW
`define OP_STW 8'h23
`endif

module mem_access_stage #(
  parameter int DMEM_ADDR_WIDTH = 13,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                        I_CLOCK,
  input  logic                        I_RESET_N,
  input  logic                        I_LOCK,
  input  logic                        I_EX_Valid,
  input  logic [`OPCODE_WIDTH-1:0]    I_Opcode,
  input  logic [`PC_WIDTH-1:0]        I_PC,
  input  logic [3:0]                  I_DestRegIdx,
  input  logic [`REG_WIDTH-1:0]       I_DestValue,
  input  logic [`REG_WIDTH-1:0]       I_MARValue,
  input  logic [`REG_WIDTH-1:0]       I_MDRValue,
  input  logic                        I_RegWEn,
  input  logic                        I_CCWEn,
  input  logic [2:0]                  I_CCValue,
  output logic                        O_DMemReq,
  output logic                        O_DMemWE,
  output logic [DMEM_ADDR_WIDTH-1:0]  O_DMemAddr,
  output logic [`REG_WIDTH-1:0]       O_DMemWData,
  output logic [3:0]                  O_DMemByteEn,
  input  logic                        I_DMemAck,
  input  logic [`REG_WIDTH-1:0]       I_DMemRData,
  output logic                        O_MEM_Valid,
  output logic [`OPCODE_WIDTH-1:0]    O_Opcode,
  output logic [`PC_WIDTH-1:0]        O_PC,
  output logic [3:0]                  O_DestRegIdx,
  output logic [`REG_WIDTH-1:0]       O_DestValue,
  output logic                        O_RegWEn,
  output logic                        O_CCWEn,
  output logic [2:0]                  O_CCValue,
  output logic                        O_MemErr,
  output logic                        O_MemStall_Signal
);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nxt;

  logic [`OPCODE_WIDTH-1:0]     cap_opcode;
  logic [`PC_WIDTH-1:0]         cap_pc;
  logic [3:0]                   cap_idx;
  logic [`REG_WIDTH-1:0]        cap_dval;
  logic [DMEM_ADDR_WIDTH+1:0]   cap_mar;
  logic [`REG_WIDTH-1:0]        cap_mdr;
  logic [2:0]                   cap_cc;

  logic accept, accept_mem, in_access, timeout_hit;
  logic cap_is_ldb, cap_is_stb, cap_is_load, cap_is_store;
  logic [7:0]                   ld_byte;
  logic [`REG_WIDTH-1:0]        ld_value;
  logic [2:0]                   ld_cc;
  logic [3:0]                   lane_onehot;
  logic                         unused_mar;

  function automatic logic is_mem_op(input logic [`OPCODE_WIDTH-1:0] op);
    return (op == `OP_LDB) || (op == `OP_LDW) || (op == `OP_STB) || (op == `OP_STW);
  endfunction

  assign in_access  = (state == ACCESS);
  assign accept     = (state == IDLE) && I_LOCK && I_EX_Valid;
  assign accept_mem = accept && is_mem_op(I_Opcode);
  assign O_MemStall_Signal = in_access;
  assign unused_mar = ^I_MARValue[`REG_WIDTH-1:DMEM_ADDR_WIDTH+2];

  assign cap_is_ldb   = (cap_opcode == `OP_LDB);
  assign cap_is_stb   = (cap_opcode == `OP_STB);
  assign cap_is_load  = cap_is_ldb || (cap_opcode == `OP_LDW);
  assign cap_is_store = cap_is_stb || (cap_opcode == `OP_STW);

`ifdef MEM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N)
      to_cnt <= '0;
    else if (accept_mem)
      to_cnt <= '0;
    else if (in_access && !I_DMemAck)
      to_cnt <= to_cnt + 1'b1;
  end

  // Fires on the edge that would bring the no-ack count to TIMEOUT_CYCLES; an ack on that edge wins.
  assign timeout_hit = in_access && !I_DMemAck && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_mem) state_nxt = ACCESS;
      ACCESS:  if (I_DMemAck || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      cap_opcode <= '0;
      cap_pc     <= '0;
      cap_idx    <= '0;
      cap_dval   <= '0;
      cap_mar    <= '0;
      cap_mdr    <= '0;
      cap_cc     <= '0;
    end else if (accept_mem) begin
      cap_opcode <= I_Opcode;
      cap_pc     <= I_PC;
      cap_idx    <= I_DestRegIdx;
      cap_dval   <= I_DestValue;
      cap_mar    <= I_MARValue[DMEM_ADDR_WIDTH+1:0];
      cap_mdr    <= I_MDRValue;
      cap_cc     <= I_CCValue;
    end
  end

  // Little-endian lane select; LDB sign-extends, LDW ignores the low address bits.
  always_comb begin
    ld_byte = 8'h00;
    case (cap_mar[1:0])
      2'd0: ld_byte = I_DMemRData[7:0];
      2'd1: ld_byte = I_DMemRData[15:8];
      2'd2: ld_byte = I_DMemRData[23:16];
      2'd3: ld_byte = I_DMemRData[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_value = cap_is_ldb ? {{(`REG_WIDTH-8){ld_byte[7]}}, ld_byte} : I_DMemRData;
    if (ld_value[`REG_WIDTH-1])
      ld_cc = 3'b100;
    else if (ld_value == '0)
      ld_cc = 3'b010;
    else
      ld_cc = 3'b001;
  end

  assign lane_onehot = 4'b0001 << cap_mar[1:0];

  always_comb begin
    O_DMemReq    = 1'b0;
    O_DMemWE     = 1'b0;
    O_DMemAddr   = '0;
    O_DMemWData  = '0;
    O_DMemByteEn = 4'b0000;
    if (in_access) begin
      O_DMemReq    = 1'b1;
      O_DMemWE     = cap_is_store;
      O_DMemAddr   = cap_mar[DMEM_ADDR_WIDTH+1:2];
      O_DMemByteEn = (cap_is_stb || cap_is_ldb) ? lane_onehot : 4'b1111;
      if (cap_is_store)
        O_DMemWData = cap_is_stb ? {(`REG_WIDTH/8){cap_mdr[7:0]}} : cap_mdr;
    end
  end

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      O_MEM_Valid  <= 1'b0;
      O_Opcode     <= '0;
      O_PC         <= '0;
      O_DestRegIdx <= '0;
      O_DestValue  <= '0;
      O_RegWEn     <= 1'b0;
      O_CCWEn      <= 1'b0;
      O_CCValue    <= '0;
      O_MemErr     <= 1'b0;
    end else begin
      O_MemErr <= 1'b0;
      if (accept && !accept_mem) begin
        O_MEM_Valid  <= 1'b1;
        O_Opcode     <= I_Opcode;
        O_PC         <= I_PC;
        O_DestRegIdx <= I_DestRegIdx;
        O_DestValue  <= I_DestValue;
        O_RegWEn     <= I_RegWEn;
        O_CCWEn      <= I_CCWEn;
        O_CCValue    <= I_CCValue;
      end else if (in_access && (I_DMemAck || timeout_hit)) begin
        O_MEM_Valid  <= 1'b1;
        O_Opcode     <= cap_opcode;
        O_PC         <= cap_pc;
        O_DestRegIdx <= cap_idx;
        if (I_DMemAck && cap_is_load) begin
          O_DestValue <= ld_value;
          O_RegWEn    <= 1'b1;
          O_CCWEn     <= 1'b1;
          O_CCValue   <= ld_cc;
        end else begin
          O_DestValue <= cap_dval;
          O_RegWEn    <= 1'b0;
          O_CCWEn     <= 1'b0;
          O_CCValue   <= cap_cc;
          O_MemErr    <= !I_DMemAck;
        end
      end else begin
        O_MEM_Valid <= 1'b0;
        O_RegWEn    <= 1'b0;
        O_CCWEn     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - Table-driven and randomized self-checking bench for mem_access_stage
// Exercises the timeout abort when built with MEM_TIMEOUT_EN.
`ifndef OP_ADD
`define OP_ADD 8'h01
`endif
`ifndef OP_LDB
`define OP_LDB 8'h20
`endif
`ifndef OP_LDW
`define OP_LDW 8'h21
`endif
`ifndef OP_STB
`define OP_STB 8'h22
`endif
`ifndef OP_STW
`define OP_STW 8'h23
`endif

module tb_mem_access_stage;
  logic        I_CLOCK = 1'b0;
  logic        I_RESET_N, I_LOCK, I_EX_Valid, I_RegWEn, I_CCWEn, I_DMemAck;
  logic [7:0]  I_Opcode;
  logic [31:0] I_PC, I_DestValue, I_MARValue, I_MDRValue, I_DMemRData;
  logic [3:0]  I_DestRegIdx;
  logic [2:0]  I_CCValue;
  logic        O_DMemReq, O_DMemWE, O_MEM_Valid, O_RegWEn, O_CCWEn, O_MemErr, O_MemStall_Signal;
  logic [12:0] O_DMemAddr;
  logic [31:0] O_DMemWData, O_PC, O_DestValue;
  logic [3:0]  O_DMemByteEn, O_DestRegIdx;
  logic [7:0]  O_Opcode;
  logic [2:0]  O_CCValue;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(.DMEM_ADDR_WIDTH(13), .TIMEOUT_CYCLES(4)) dut (
    .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK), .I_EX_Valid(I_EX_Valid),
    .I_Opcode(I_Opcode), .I_PC(I_PC), .I_DestRegIdx(I_DestRegIdx), .I_DestValue(I_DestValue),
    .I_MARValue(I_MARValue), .I_MDRValue(I_MDRValue), .I_RegWEn(I_RegWEn), .I_CCWEn(I_CCWEn),
    .I_CCValue(I_CCValue), .O_DMemReq(O_DMemReq), .O_DMemWE(O_DMemWE), .O_DMemAddr(O_DMemAddr),
    .O_DMemWData(O_DMemWData), .O_DMemByteEn(O_DMemByteEn), .I_DMemAck(I_DMemAck),
    .I_DMemRData(I_DMemRData), .O_MEM_Valid(O_MEM_Valid), .O_Opcode(O_Opcode), .O_PC(O_PC),
    .O_DestRegIdx(O_DestRegIdx), .O_DestValue(O_DestValue), .O_RegWEn(O_RegWEn),
    .O_CCWEn(O_CCWEn), .O_CCValue(O_CCValue), .O_MemErr(O_MemErr),
    .O_MemStall_Signal(O_MemStall_Signal)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] pc;
    logic [3:0]  idx;
    logic [31:0] dval, mar, mdr;
    logic        rwe, cwe;
    logic [2:0]  cc;
  } ins_t;

  typedef struct {
    ins_t        ins;
    logic [31:0] rdata;
    int          ack_edge;
    logic [31:0] e_dest;
    logic [2:0]  e_cc;
    logic        e_rwe, e_cwe;
    logic [12:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // DUT state changes on the falling edge; sample and drive 2 time units after it.
  task automatic tick();
    @(negedge I_CLOCK);
    #2;
  endtask

  task automatic drive(input ins_t x);
    I_Opcode = x.op; I_PC = x.pc; I_DestRegIdx = x.idx; I_DestValue = x.dval;
    I_MARValue = x.mar; I_MDRValue = x.mdr; I_RegWEn = x.rwe; I_CCWEn = x.cwe; I_CCValue = x.cc;
  endtask

  function automatic bit is_mem(input logic [7:0] op);
    return op == `OP_LDB || op == `OP_LDW || op == `OP_STB || op == `OP_STW;
  endfunction

  function automatic bit is_store(input logic [7:0] op);
    return op == `OP_STB || op == `OP_STW;
  endfunction

  function automatic logic [31:0] load_value(input ins_t x, input logic [31:0] rd);
    int b;
    if (x.op == `OP_LDW) return rd;
    b = int'((rd >> (8 * (x.mar % 4))) & 32'hFF);
    if (b >= 128) b = b - 256;
    return 32'(b);
  endfunction

  function automatic logic [2:0] cc_of(input logic [31:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 0) return 3'b010;
    return 3'b001;
  endfunction

  function automatic ins_t rand_ins();
    ins_t x;
    case ($urandom_range(0, 5))
      0: x.op = `OP_LDB;
      1: x.op = `OP_LDW;
      2: x.op = `OP_STB;
      3: x.op = `OP_STW;
      default: x.op = 8'($urandom_range(0, 15));
    endcase
    x.pc = $urandom; x.idx = 4'($urandom); x.dval = $urandom; x.mar = $urandom; x.mdr = $urandom;
    x.rwe = 1'($urandom); x.cwe = 1'($urandom); x.cc = 3'($urandom);
    return x;
  endfunction

  task automatic check_wb(input string tag, input ins_t x, input logic [31:0] rd, input bit acked);
    chk({tag, "_valid"}, O_MEM_Valid, 1);
    chk({tag, "_opcode"}, O_Opcode, x.op);
    chk({tag, "_pc"}, O_PC, x.pc);
    chk({tag, "_idx"}, O_DestRegIdx, x.idx);
    if (!is_mem(x.op)) begin
      chk({tag, "_dest"}, O_DestValue, x.dval);
      chk({tag, "_rwe"}, O_RegWEn, x.rwe);
      chk({tag, "_cwe"}, O_CCWEn, x.cwe);
      chk({tag, "_cc"}, O_CCValue, x.cc);
    end else if (acked && !is_store(x.op)) begin
      chk({tag, "_dest"}, O_DestValue, load_value(x, rd));
      chk({tag, "_rwe"}, O_RegWEn, 1);
      chk({tag, "_cwe"}, O_CCWEn, 1);
      chk({tag, "_cc"}, O_CCValue, cc_of(load_value(x, rd)));
    end else begin
      chk({tag, "_rwe"}, O_RegWEn, 0);
      chk({tag, "_cwe"}, O_CCWEn, 0);
      chk({tag, "_cc"}, O_CCValue, x.cc);
    end
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int stalls;
    drive(v.ins); I_EX_Valid = 1; I_LOCK = 1; I_DMemAck = 0;
    tick();
    I_EX_Valid = 0;
    if (!is_mem(v.ins.op)) begin
      chk($sformatf("v%0d_valid", i), O_MEM_Valid, 1);
      chk($sformatf("v%0d_stall", i), O_MemStall_Signal, 0);
      chk($sformatf("v%0d_dest", i), O_DestValue, v.e_dest);
    end else begin
      stalls = 0;
      chk($sformatf("v%0d_early_valid", i), O_MEM_Valid, 0);
      for (int k = 0; k < v.ack_edge; k++) begin
        stalls += int'(O_MemStall_Signal);
        chk($sformatf("v%0d_req", i), O_DMemReq, 1);
        chk($sformatf("v%0d_addr", i), O_DMemAddr, v.e_addr);
        chk($sformatf("v%0d_we", i), O_DMemWE, is_store(v.ins.op));
        if (is_store(v.ins.op)) begin
          chk($sformatf("v%0d_be", i), O_DMemByteEn, v.e_be);
          chk($sformatf("v%0d_wdata", i), O_DMemWData, v.e_wdata);
        end
        I_DMemAck = (k == v.ack_edge - 1);
        I_DMemRData = v.rdata;
        tick();
      end
      I_DMemAck = 0;
      chk($sformatf("v%0d_stall_cycles", i), stalls, v.ack_edge);
      chk($sformatf("v%0d_valid", i), O_MEM_Valid, 1);
      chk($sformatf("v%0d_req_drop", i), O_DMemReq, 0);
      if (!is_store(v.ins.op)) chk($sformatf("v%0d_dest", i), O_DestValue, v.e_dest);
    end
    chk($sformatf("v%0d_rwe", i), O_RegWEn, v.e_rwe);
    chk($sformatf("v%0d_cwe", i), O_CCWEn, v.e_cwe);
    chk($sformatf("v%0d_cc", i), O_CCValue, v.e_cc);
    chk($sformatf("v%0d_pc", i), O_PC, v.ins.pc);
    tick();
    chk($sformatf("v%0d_pulse", i), O_MEM_Valid, 0);
  endtask

  vec_t vt[9];
  ins_t a, b, cur, fly;
  bit have, inflight, exp_v;
  int ack_cd;
  logic [31:0] rd;

  initial begin
    I_RESET_N = 0; I_LOCK = 0; I_EX_Valid = 0; I_DMemAck = 0; I_DMemRData = 0;
    a = '{op: 8'h00, pc: 0, idx: 0, dval: 0, mar: 0, mdr: 0, rwe: 0, cwe: 0, cc: 0};
    drive(a);
    //             op      pc        idx dval          mar           mdr           rwe cwe cc        rdata         ack  e_dest        e_cc    rwe cwe addr      be       wdata
    vt[0] = '{'{`OP_ADD, 32'h1000, 1, 32'h00000005, 32'h0,        32'h0,        1, 1, 3'b001}, 32'h0,        0, 32'h00000005, 3'b001, 1, 1, 13'h0,    4'b0000, 32'h0};
    vt[1] = '{'{`OP_STB, 32'h1004, 2, 32'h0,        32'h00000102, 32'h000000AB, 1, 1, 3'b010}, 32'h0,        3, 32'h0,        3'b010, 0, 0, 13'h40,   4'b0100, 32'hABABABAB};
    vt[2] = '{'{`OP_LDB, 32'h1008, 3, 32'h0,        32'h00000103, 32'h0,        1, 1, 3'b001}, 32'h80FF0000, 1, 32'hFFFFFF80, 3'b100, 1, 1, 13'h40,   4'b1000, 32'h0};
    vt[3] = '{'{`OP_LDW, 32'h100C, 4, 32'h0,        32'h00002007, 32'h0,        0, 0, 3'b000}, 32'h12345678, 2, 32'h12345678, 3'b001, 1, 1, 13'h801,  4'b1111, 32'h0};
    vt[4] = '{'{`OP_STW, 32'h1010, 5, 32'h0,        32'h00000010, 32'hDEADBEEF, 1, 1, 3'b100}, 32'h0,        1, 32'h0,        3'b100, 0, 0, 13'h4,    4'b1111, 32'hDEADBEEF};
    vt[5] = '{'{`OP_LDB, 32'h1014, 6, 32'h0,        32'h00000001, 32'h0,        0, 0, 3'b100}, 32'h00007F00, 4, 32'h0000007F, 3'b001, 1, 1, 13'h0,    4'b0010, 32'h0};
    vt[6] = '{'{`OP_LDW, 32'h1018, 7, 32'h0,        32'h00000008, 32'h0,        1, 0, 3'b100}, 32'h0,        1, 32'h0,        3'b010, 1, 1, 13'h2,    4'b1111, 32'h0};
    vt[7] = '{'{`OP_LDB, 32'h101C, 8, 32'h0,        32'hFFF7FFFC, 32'h0,        1, 1, 3'b001}, 32'h000000FE, 2, 32'hFFFFFFFE, 3'b100, 1, 1, 13'h1FFF, 4'b0001, 32'h0};
    vt[8] = '{'{8'h05,   32'h1020, 9, 32'hCAFEF00D, 32'h0,        32'h0,        0, 1, 3'b100}, 32'h0,        0, 32'hCAFEF00D, 3'b100, 0, 1, 13'h0,    4'b0000, 32'h0};

    #8;
    chk("rst_valid", O_MEM_Valid, 0);
    chk("rst_req", O_DMemReq, 0);
    chk("rst_stall", O_MemStall_Signal, 0);
    chk("rst_dest", O_DestValue, 0);
    chk("rst_memerr", O_MemErr, 0);
    #5 I_RESET_N = 1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // Ack while IDLE must be ignored.
    I_DMemAck = 1; tick(); I_DMemAck = 0;
    chk("idle_ack_valid", O_MEM_Valid, 0);
    chk("idle_ack_stall", O_MemStall_Signal, 0);

    // LDW with ADD held behind the stall; ack on the 2nd ACCESS edge.
    a = '{op: `OP_LDW, pc: 32'h2000, idx: 4'd3, dval: 0, mar: 32'h40, mdr: 0, rwe: 0, cwe: 0, cc: 0};
    b = '{op: `OP_ADD, pc: 32'h2004, idx: 4'd4, dval: 32'h77, mar: 0, mdr: 0, rwe: 1, cwe: 1, cc: 3'b001};
    drive(a); I_EX_Valid = 1; I_LOCK = 1;
    tick();
    drive(b);
    chk("seq_stall0", O_MemStall_Signal, 1);
    tick();
    chk("seq_stall1", O_MemStall_Signal, 1);
    chk("seq_novalid", O_MEM_Valid, 0);
    I_DMemAck = 1; I_DMemRData = 32'h8000_0001;
    tick();
    I_DMemAck = 0;
    check_wb("seq_ldw", a, 32'h8000_0001, 1);
    tick();
    check_wb("seq_add", b, 0, 0);
    I_EX_Valid = 0;
    tick();
    chk("seq_nodup", O_MEM_Valid, 0);

    // Asynchronous reset in the middle of an access.
    a = '{op: `OP_STW, pc: 32'h3000, idx: 4'd1, dval: 0, mar: 32'h80, mdr: 32'h5A5A5A5A, rwe: 0, cwe: 0, cc: 0};
    drive(a); I_EX_Valid = 1;
    tick();
    I_EX_Valid = 0;
    chk("ar_req_before", O_DMemReq, 1);
    #1 I_RESET_N = 0;
    #1;
    chk("ar_req", O_DMemReq, 0);
    chk("ar_stall", O_MemStall_Signal, 0);
    chk("ar_addr", O_DMemAddr, 0);
    chk("ar_wdata", O_DMemWData, 0);
    chk("ar_pc", O_PC, 0);
    chk("ar_opcode", O_Opcode, 0);
    #1 I_RESET_N = 1;
    tick();
    chk("ar_idle_req", O_DMemReq, 0);
    chk("ar_idle_valid", O_MEM_Valid, 0);

    // I_LOCK=0 blocks new accepts.
    drive(b); I_EX_Valid = 1; I_LOCK = 0;
    tick();
    chk("lock_off_valid", O_MEM_Valid, 0);
    I_LOCK = 1;
    tick();
    check_wb("lock_on", b, 0, 0);
    I_EX_Valid = 0;
    tick();

    a = '{op: `OP_LDB, pc: 32'h4000, idx: 4'd2, dval: 32'h1111, mar: 32'h44, mdr: 0, rwe: 1, cwe: 1, cc: 3'b010};
    drive(a); I_EX_Valid = 1;
    tick();
    I_EX_Valid = 0;
`ifdef MEM_TIMEOUT_EN
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("to_wait_req", O_DMemReq, 1);
      chk("to_wait_err", O_MemErr, 0);
    end
    tick();
    chk("to_err", O_MemErr, 1);
    chk("to_valid", O_MEM_Valid, 1);
    chk("to_rwe", O_RegWEn, 0);
    chk("to_cwe", O_CCWEn, 0);
    chk("to_req", O_DMemReq, 0);
    tick();
    chk("to_err_pulse", O_MemErr, 0);
    chk("to_valid_pulse", O_MEM_Valid, 0);
`else
    for (int k = 0; k < 70; k++) begin
      tick();
      chk("wait_req", O_DMemReq, 1);
      chk("wait_err", O_MemErr, 0);
    end
    I_DMemAck = 1; I_DMemRData = 32'h0000_0000;
    tick();
    I_DMemAck = 0;
    check_wb("late_ack", a, 32'h0, 1);
    tick();
`endif

    // Randomized traffic against a transaction-level model.
    have = 0; inflight = 0; ack_cd = 0;
    for (int c = 0; c < 800; c++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        cur = rand_ins();
        have = 1;
      end
      if (have) drive(cur);
      I_EX_Valid = have;
      I_LOCK = ($urandom_range(0, 6) != 0);
      rd = $urandom;
      I_DMemRData = rd;
      I_DMemAck = inflight ? (ack_cd == 0) : ($urandom_range(0, 4) == 0);
      chk("rnd_stall", O_MemStall_Signal, inflight);
      chk("rnd_req", O_DMemReq, inflight);
      if (inflight) begin
        chk("rnd_addr", O_DMemAddr, (fly.mar >> 2) & 32'h1FFF);
        chk("rnd_we", O_DMemWE, is_store(fly.op));
        if (fly.op == `OP_STB) begin
          chk("rnd_be", O_DMemByteEn, 32'h1 << (fly.mar % 4));
          chk("rnd_wdata", O_DMemWData, (fly.mdr & 32'hFF) * 32'h01010101);
        end else if (fly.op == `OP_STW) begin
          chk("rnd_be", O_DMemByteEn, 32'hF);
          chk("rnd_wdata", O_DMemWData, fly.mdr);
        end
      end
      tick();
      exp_v = 0;
      if (inflight) begin
        if (I_DMemAck) begin
          exp_v = 1;
          inflight = 0;
          check_wb("rnd_mem", fly, rd, 1);
        end else begin
          ack_cd--;
        end
      end else if (I_LOCK && have) begin
        have = 0;
        if (is_mem(cur.op)) begin
          fly = cur;
          inflight = 1;
          ack_cd = $urandom_range(0, 2);
        end else begin
          exp_v = 1;
          check_wb("rnd_alu", cur, 0, 0);
        end
      end
      if (!exp_v) chk("rnd_valid", O_MEM_Valid, 0);
      chk("rnd_memerr", O_MemErr, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
